// File: rtl/pm_loader.sv
// rtl/pm_loader.sv - serial bootloader that assembles MSB-first bits into program-memory writes
// Holds the CPU in reset while a program image is streamed in.

module pm_loader #(
    parameter int ADD_WIDTH  = 7,
    parameter int DATA_WIDTH = 8,
    parameter int PROG_BYTES = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  load_end,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    output logic                  pmWrEn,
    output logic [ADD_WIDTH-1:0]  pm_addr,
    output logic [DATA_WIDTH-1:0] instructionIn,
    output logic                  cpu_rst,
    output logic                  load_busy,
    output logic                  load_done,
    output logic [ADD_WIDTH:0]    byte_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADD_WIDTH-1:0] ADDR_ONE  = 1;
    localparam logic [ADD_WIDTH:0]   CNT_ONE   = 1;
    localparam logic [ADD_WIDTH:0]   CNT_LAST  = (ADD_WIDTH+1)'(PROG_BYTES);

    state_t                  state, state_next;
    logic [2:0]              bit_cnt, bit_cnt_next;
    logic [7:0]              shift_reg, shift_next;
    logic [ADD_WIDTH-1:0]    addr, addr_next;
    logic [ADD_WIDTH:0]      count_next;
    logic [ADD_WIDTH-1:0]    pm_addr_next;
    logic [DATA_WIDTH-1:0]   instr_next;
    logic                    wr_next;
    logic                    cpu_rst_next;
    logic                    busy_next;
    logic                    done_next;
    logic [7:0]              full_byte;

    assign full_byte = {shift_reg[6:0], bit_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bit_cnt       <= 3'd0;
            shift_reg     <= 8'd0;
            addr          <= '0;
            byte_count    <= '0;
            pm_addr       <= '0;
            instructionIn <= '0;
            pmWrEn        <= 1'b0;
            cpu_rst       <= 1'b1;
            load_busy     <= 1'b0;
            load_done     <= 1'b0;
        end else begin
            state         <= state_next;
            bit_cnt       <= bit_cnt_next;
            shift_reg     <= shift_next;
            addr          <= addr_next;
            byte_count    <= count_next;
            pm_addr       <= pm_addr_next;
            instructionIn <= instr_next;
            pmWrEn        <= wr_next;
            cpu_rst       <= cpu_rst_next;
            load_busy     <= busy_next;
            load_done     <= done_next;
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift_reg;
        addr_next    = addr;
        count_next   = byte_count;
        pm_addr_next = pm_addr;
        instr_next   = instructionIn;
        wr_next      = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (load_start) begin
                    state_next   = LOAD;
                    bit_cnt_next = 3'd0;
                    shift_next   = 8'd0;
                    addr_next    = '0;
                    count_next   = '0;
                end
            end
            LOAD: begin
                if (bit_valid) begin
                    shift_next   = full_byte;
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        wr_next      = 1'b1;
                        pm_addr_next = addr;
                        instr_next   = DATA_WIDTH'(full_byte);
                        addr_next    = addr + ADDR_ONE;
                        count_next   = byte_count + CNT_ONE;
                        if (count_next == CNT_LAST) begin
                            state_next = DONE;
                        end
                    end
                end
                // Early end drops any partial byte; a completing 8th bit has already written above.
                if (load_end) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        cpu_rst_next = (state_next != DONE);
        busy_next    = (state_next == LOAD);
        done_next    = (state_next == DONE);
    end

endmodule
